// File: rtl/seg_scan_if.sv
// Display scan controller bus: write port for the pending buffer and the
// anode/segment outputs toward the display.
interface seg_scan_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIG_N  = 4;

    logic              run;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DIG_N-1:0]  wr_dp;
    logic [DIG_N-1:0]  wr_blank;
    logic [DIG_N-1:0]  an;
    logic [3:0]        digit;
    logic              dp_n;
    logic              frame_done;
    logic              pending;

    modport master (
        output run, wr_en, wr_data, wr_dp, wr_blank,
        input  an, digit, dp_n, frame_done, pending
    );

    modport slave (
        input  run, wr_en, wr_data, wr_dp, wr_blank,
        output an, digit, dp_n, frame_done, pending
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scan controller with dead-time blanking and a
// double-buffered display register committed only at frame boundaries.
module seg_scan_controller #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned ON_CYCLES   = 16
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(0);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    disp_t            sh_q, sh_d;
    disp_t            pd_q, pd_d;
    logic             pend_q, pend_d;
    logic             fdone_q, fdone_d;

    logic [3:0]       an_c;
    logic             dp_n_c;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BLANK;
            idx_q   <= IDX_FIRST;
            cnt_q   <= '0;
            sh_q    <= '0;
            pd_q    <= '0;
            pend_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            pd_q    <= pd_d;
            pend_q  <= pend_d;
            fdone_q <= fdone_d;
        end
    end

    // Slot sequencing, frame commit and pending-buffer writes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        pd_d    = pd_q;
        pend_d  = pend_q;
        fdone_d = 1'b0;

        if (!bus.run) begin
            state_d = ST_BLANK;
            idx_d   = IDX_FIRST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_BLANK: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q - IDX_W'(1);
                        // Leaving digit 0 closes the frame: commit the pending set.
                        if (idx_q == IDX_LAST) begin
                            fdone_d = 1'b1;
                            if (pend_q) begin
                                sh_d   = pd_q;
                                pend_d = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end

        // A write always lands in the pending set, even in the commit cycle.
        if (bus.wr_en) begin
            pd_d   = '{data: bus.wr_data, dp: bus.wr_dp, blank: bus.wr_blank};
            pend_d = 1'b1;
        end
    end

    // Anode and decimal-point decode from registered state only.
    always_comb begin
        an_c   = 4'hF;
        dp_n_c = 1'b1;
        if (state_q == ST_ON && !sh_q.blank[idx_q]) begin
            an_c[idx_q] = 1'b0;
            dp_n_c      = ~sh_q.dp[idx_q];
        end
    end

    assign bus.an         = an_c;
    assign bus.dp_n       = dp_n_c;
    assign bus.digit      = sh_q.data[{idx_q, 2'b00} +: 4];
    assign bus.frame_done = fdone_q;
    assign bus.pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with DEAD=2, ON=4 (24-cycle frame).
module tb_seg_scan_controller;
    localparam int unsigned DEAD = 2;
    localparam int unsigned ON   = 4;
    localparam int N_CYC = 152;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] digit;
        logic       dp_n;
        logic       fd;
        logic       pend;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t rows[$];

    seg_scan_if bus();

    seg_scan_controller #(.DEAD_CYCLES(DEAD), .ON_CYCLES(ON)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int c, input logic [3:0] a, input logic [3:0] d,
                       input logic p, input logic f, input logic pe);
        exp_t r;
        r.cyc = c; r.an = a; r.digit = d; r.dp_n = p; r.fd = f; r.pend = pe;
        rows.push_back(r);
    endtask

    // Per-cycle stimulus: writes, run hold and a mid-slot reset.
    task automatic drive(input int c);
        reset        = 1'b1;
        bus.run      = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 16'h0000;
        bus.wr_dp    = 4'h0;
        bus.wr_blank = 4'h0;
        case (c)
            3:   begin bus.wr_en = 1'b1; bus.wr_data = 16'h1234; end
            46:  begin bus.wr_en = 1'b1; bus.wr_data = 16'hA5C3; bus.wr_dp = 4'b0001; bus.wr_blank = 4'b0100; end
            47:  begin bus.wr_en = 1'b1; bus.wr_data = 16'h9876; end
            117: begin bus.wr_en = 1'b1; bus.wr_data = 16'hFFFF; bus.wr_dp = 4'hF; end
            125: reset = 1'b0;
            default: ;
        endcase
        if (c >= 87 && c <= 91) bus.run = 1'b0;
    endtask

    initial begin
        //  cyc  an     digit  dp_n fd  pend
        add(0,   4'hF, 4'h0, 1, 0, 0);
        add(1,   4'hF, 4'h0, 1, 0, 0);
        add(2,   4'h7, 4'h0, 1, 0, 0);
        add(5,   4'h7, 4'h0, 1, 0, 1);
        add(6,   4'hF, 4'h0, 1, 0, 1);
        add(8,   4'hB, 4'h0, 1, 0, 1);
        add(23,  4'hE, 4'h0, 1, 0, 1);
        add(24,  4'hF, 4'h1, 1, 1, 0);
        add(25,  4'hF, 4'h1, 1, 0, 0);
        add(26,  4'h7, 4'h1, 1, 0, 0);
        add(32,  4'hB, 4'h2, 1, 0, 0);
        add(38,  4'hD, 4'h3, 1, 0, 0);
        add(44,  4'hE, 4'h4, 1, 0, 0);
        add(47,  4'hE, 4'h4, 1, 0, 1);
        add(48,  4'hF, 4'hA, 1, 1, 1);
        add(50,  4'h7, 4'hA, 1, 0, 1);
        add(56,  4'hF, 4'h5, 1, 0, 1);
        add(62,  4'hD, 4'hC, 1, 0, 1);
        add(66,  4'hF, 4'h3, 1, 0, 1);
        add(68,  4'hE, 4'h3, 0, 0, 1);
        add(71,  4'hE, 4'h3, 0, 0, 1);
        add(72,  4'hF, 4'h9, 1, 1, 0);
        add(74,  4'h7, 4'h9, 1, 0, 0);
        add(86,  4'hD, 4'h7, 1, 0, 0);
        add(87,  4'hD, 4'h7, 1, 0, 0);
        add(88,  4'hF, 4'h9, 1, 0, 0);
        add(92,  4'hF, 4'h9, 1, 0, 0);
        add(93,  4'hF, 4'h9, 1, 0, 0);
        add(94,  4'h7, 4'h9, 1, 0, 0);
        add(112, 4'hE, 4'h6, 1, 0, 0);
        add(116, 4'hF, 4'h9, 1, 1, 0);
        add(117, 4'hF, 4'h9, 1, 0, 0);
        add(118, 4'h7, 4'h9, 1, 0, 1);
        add(124, 4'hB, 4'h8, 1, 0, 1);
        add(125, 4'hB, 4'h8, 1, 0, 1);
        add(126, 4'hF, 4'h0, 1, 0, 0);
        add(127, 4'hF, 4'h0, 1, 0, 0);
        add(128, 4'h7, 4'h0, 1, 0, 0);
        add(150, 4'hF, 4'h0, 1, 1, 0);

        reset        = 1'b0;
        bus.run      = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 16'h0000;
        bus.wr_dp    = 4'h0;
        bus.wr_blank = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an",    -1, 16'(bus.an),         16'hF);
        check("reset_digit", -1, 16'(bus.digit),      16'h0);
        check("reset_dp_n",  -1, 16'(bus.dp_n),       16'h1);
        check("reset_fd",    -1, 16'(bus.frame_done), 16'h0);
        check("reset_pend",  -1, 16'(bus.pending),    16'h0);

        for (int c = 0; c < N_CYC; c++) begin
            drive(c);
            @(negedge clk);
            check("one_hot_an", c, 16'($countones(~bus.an) <= 1), 16'h1);
            foreach (rows[i]) begin
                if (rows[i].cyc == c) begin
                    check("an",    c, 16'(bus.an),         16'(rows[i].an));
                    check("digit", c, 16'(bus.digit),      16'(rows[i].digit));
                    check("dp_n",  c, 16'(bus.dp_n),       16'(rows[i].dp_n));
                    check("fd",    c, 16'(bus.frame_done), 16'(rows[i].fd));
                    check("pend",  c, 16'(bus.pending),    16'(rows[i].pend));
                end
            end
            // No frame commit may be signalled during the run hold.
            if (c >= 88 && c <= 93)
                check("hold_no_fd", c, 16'(bus.frame_done), 16'h0);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the 4-digit 7-segment display. Sequences the shared cathode bus between the four digits: it drives one active-low anode at a time, presents that digit's nibble to the existing hex-to-segment decoder, and inserts a dead-time between slots to prevent ghosting. A double-buffered data register accepts new display contents at any time. Those contents are committed only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- DEAD_CYCLES, 4, blanking cycles at the start of each digit slot (1..65535)
- ON_CYCLES, 16, anode-active cycles per digit slot (1..65535)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- run  input  1  1 = scanning; 0 = hold blank and restart the scan
- wr_en  input  1  write strobe for the pending buffer
- wr_data  input  16  four nibbles; [15:12] = digit 3 … [3:0] = digit 0
- wr_dp  input  4  decimal-point enables per digit, 1 = on
- wr_blank  input  4  per-digit blank mask, 1 = digit dark
- an  output  4  active-low anodes; an[i] drives digit i
- digit  output  4  nibble to the segment decoder
- dp_n  output  1  active-low decimal point
- frame_done  output  1  one-cycle pulse at each frame commit
- pending  output  1  1 = a write is waiting for a frame boundary

## Operation
- Registers:
  - shadow set: data[15:0], dp[3:0], blank[3:0]. Drives the outputs.
  - pending set: same fields, plus the pending flag.
  - state ∈ {BLANK, ON}.
  - idx[1:0], the current digit.
  - cnt[15:0].
- Scan order: idx 3 → 2 → 1 → 0 → 3 (wraps).
- BLANK state:
  - an = 4'b1111.
  - When cnt == DEAD_CYCLES-1: next state ON, cnt ← 0. Otherwise cnt++.
- ON state:
  - an[idx] = 0 unless shadow blank[idx] = 1; all other an bits = 1.
  - When cnt == ON_CYCLES-1: next state BLANK, cnt ← 0, idx ← idx-1. Otherwise cnt++.
- Output decode:
  - digit = shadow data[4*idx+3 : 4*idx] in both states.
  - dp_n = ~(shadow dp[idx]) in ON state with the digit not blanked; dp_n = 1 otherwise.
- Frame commit, on the ON→BLANK transition out of idx 0:
  - If pending = 1: shadow ← pending set, and pending ← 0 unless wr_en is asserted that same cycle.
  - frame_done = 1 for the following cycle, whether or not anything was committed.
- Writes:
  - wr_en = 1 loads the pending set and sets pending = 1.
  - A later write before the commit overwrites the earlier one (last write wins).
- Write in the commit cycle:
  - The commit takes the previously pending value.
  - wr_data goes into the pending set and pending stays 1.
  - The new data is committed at the next frame.
- run = 0 (sampled each cycle):
  - Next state BLANK, idx ← 3, cnt ← 0, frame_done ← 0.
  - The pending buffer still accepts writes.
  - No commit occurs while run = 0.
- Reset (reset = 0 at a clock edge), overriding everything including mid-slot and mid-write:
  - state BLANK, idx 3, cnt 0.
  - Shadow and pending sets all 0; pending flag 0.
  - frame_done 0.

## Timing
- All outputs are functions of registers only (Moore). There is no combinational path from any input to any output.
- Reset values:
  - an = 4'hF, digit = 4'h0, dp_n = 1, frame_done = 0, pending = 0.
- First active anode:
  - an[3] goes low DEAD_CYCLES cycles after the first edge with reset = 1 and run = 1.
  - It stays low for exactly ON_CYCLES cycles.
- Periods:
  - Slot period = DEAD_CYCLES + ON_CYCLES.
  - Frame period = 4 × slot period.
- Anode rules:
  - Never more than one an bit low.
  - Consecutive anodes are always separated by ≥ DEAD_CYCLES cycles of an = 4'hF.
- digit changes only on the first cycle of BLANK, so it is stable throughout each anode-active window.
- pending:
  - Rises the cycle after wr_en.
  - Falls the cycle frame_done is high, unless a write occurred in the commit cycle.
- Maximum write-to-display latency: one frame period + 1 cycle.

## Test plan
- Reset and run-up (DEAD=2, ON=4, run=1, reset released at cycle 0):
  - an = F for cycles 0–1, E…wait: an = 4'b0111 for cycles 2–5.
  - an = F for cycles 6–7, then 4'b1011 for cycles 8–11.
  - frame_done pulses at cycle 24.
- Double buffer (wr_en with wr_data = 16'h1234 at cycle 3, mid-frame):
  - Digits show 0 for the rest of frame 1.
  - frame_done at cycle 24; from cycle 24, digit = 1, 2, 3, 4 in slots 3..0.
  - pending falls at cycle 24.
- Write collision (wr_en with data A one cycle before the commit edge, wr_en with data B on the commit cycle):
  - Frame 2 shows A, frame 3 shows B.
  - pending stays high across the first commit.
- Blank and dp (wr_blank = 4'b0100, wr_dp = 4'b0001, committed):
  - an[2] never goes low.
  - dp_n = 0 only while an[0] is low.
  - The slot timing for digit 2 is unchanged (an stays F).
- run toggle (run = 0 mid-ON of digit 1 for 5 cycles, then run = 1):
  - an = F on the next cycle and throughout the hold.
  - Scan restarts at digit 3 after DEAD cycles.
  - No frame_done during the hold.
- Reset mid-operation (reset = 0 for one cycle while digit 2 is active with pending = 1):
  - All outputs return to their reset values.
  - Pending data is discarded; the display shows 0000.
